// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: valid/ready handshake, optional skid entry, flush,
// load-use hazard detection and a saturating bubble counter.
module id_ex_pipe_reg #(
    parameter int DATA_W      = 32,
    parameter int REG_W       = 5,
    parameter int CTRL_W      = 9,
    parameter int MEMREAD_BIT = 5,
    parameter int SKID        = 1,
    parameter int HAZARD_EN   = 1,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [DATA_W-1:0] in_rs_data,
    input  logic [DATA_W-1:0] in_rt_data,
    input  logic [DATA_W-1:0] in_imm,
    input  logic [REG_W-1:0]  in_rs,
    input  logic [REG_W-1:0]  in_rt,
    input  logic [REG_W-1:0]  in_rd,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_rs_data,
    output logic [DATA_W-1:0] out_rt_data,
    output logic [DATA_W-1:0] out_imm,
    output logic [REG_W-1:0]  out_rs,
    output logic [REG_W-1:0]  out_rt,
    output logic [REG_W-1:0]  out_rd,
    output logic              hazard_stall,
    output logic [CNT_W-1:0]  bubble_cnt
);

    // Payload layout, MSB first: {ctrl, pc, rs_data, rt_data, imm, rs, rt, rd}
    localparam int PW     = CTRL_W + 4*DATA_W + 3*REG_W;
    localparam int MR_POS = PW - CTRL_W + MEMREAD_BIT;

    logic [PW-1:0]    in_payload;
    logic [PW-1:0]    m_payload_reg;
    logic [PW-1:0]    s_payload_reg;
    logic             m_valid_reg;
    logic             s_valid_reg;
    logic             accept;
    logic             drain;
    logic [CNT_W-1:0] bubble_cnt_reg;

    assign in_payload = {in_ctrl, in_pc, in_rs_data, in_rt_data, in_imm, in_rs, in_rt, in_rd};
    assign accept     = in_valid & in_ready & ~hazard_stall & ~flush;
    assign drain      = m_valid_reg & out_ready;

    // Load-use check against every held entry (M = 0, S = 1)
    logic [1:0]    held_valid;
    logic [PW-1:0] held_payload [2];
    logic [1:0]    hit;

    assign held_valid      = {s_valid_reg, m_valid_reg};
    assign held_payload[0] = m_payload_reg;
    assign held_payload[1] = s_payload_reg;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_hazard
            logic [REG_W-1:0] e_rt;
            assign e_rt    = held_payload[gi][2*REG_W-1:REG_W];
            assign hit[gi] = held_valid[gi] & held_payload[gi][MR_POS] & (e_rt != '0)
                           & ((e_rt == in_rs) | (e_rt == in_rt));
        end

        if (HAZARD_EN != 0) begin : g_haz_on
            assign hazard_stall = in_valid & ~flush & (|hit);
        end else begin : g_haz_off
            assign hazard_stall = 1'b0;
        end
    endgenerate

    generate
        if (SKID != 0) begin : g_skid
            assign in_ready = ~s_valid_reg;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    m_valid_reg   <= 1'b0;
                    s_valid_reg   <= 1'b0;
                    m_payload_reg <= '0;
                    s_payload_reg <= '0;
                end else if (flush) begin
                    m_valid_reg <= 1'b0;
                    s_valid_reg <= 1'b0;
                end else if (drain && s_valid_reg) begin
                    // Skid entry refills M ahead of any new input
                    m_payload_reg <= s_payload_reg;
                    m_valid_reg   <= 1'b1;
                    if (accept) begin
                        s_payload_reg <= in_payload;
                    end
                    s_valid_reg <= accept;
                end else if (!m_valid_reg || drain) begin
                    if (accept) begin
                        m_payload_reg <= in_payload;
                    end
                    m_valid_reg <= accept;
                end else if (accept) begin
                    s_payload_reg <= in_payload;
                    s_valid_reg   <= 1'b1;
                end
            end
        end else begin : g_noskid
            assign in_ready      = ~m_valid_reg | out_ready;
            assign s_valid_reg   = 1'b0;
            assign s_payload_reg = '0;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    m_valid_reg   <= 1'b0;
                    m_payload_reg <= '0;
                end else if (flush) begin
                    m_valid_reg <= 1'b0;
                end else if (accept) begin
                    m_payload_reg <= in_payload;
                    m_valid_reg   <= 1'b1;
                end else if (drain) begin
                    m_valid_reg <= 1'b0;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bubble_cnt_reg <= '0;
        end else if (!m_valid_reg && (bubble_cnt_reg != {CNT_W{1'b1}})) begin
            bubble_cnt_reg <= bubble_cnt_reg + CNT_W'(1);
        end
    end

    // A bubble carries no control, so it can never write the register file or memory
    assign out_valid   = m_valid_reg;
    assign out_ctrl    = m_valid_reg ? m_payload_reg[PW-1 -: CTRL_W] : '0;
    assign out_pc      = m_payload_reg[3*REG_W + 4*DATA_W - 1 -: DATA_W];
    assign out_rs_data = m_payload_reg[3*REG_W + 3*DATA_W - 1 -: DATA_W];
    assign out_rt_data = m_payload_reg[3*REG_W + 2*DATA_W - 1 -: DATA_W];
    assign out_imm     = m_payload_reg[3*REG_W + DATA_W - 1 -: DATA_W];
    assign out_rs      = m_payload_reg[3*REG_W-1 -: REG_W];
    assign out_rt      = m_payload_reg[2*REG_W-1 -: REG_W];
    assign out_rd      = m_payload_reg[REG_W-1:0];
    assign bubble_cnt  = bubble_cnt_reg;

endmodule
